// File: rtl/cska_pkg.sv
// Shared constants for the 32-bit carry-skip adder.
package cska_pkg;
  localparam int DATA_W      = 32;
  localparam int DEF_BLOCK_W = 4;
  localparam int NUM_BLK     = DATA_W / DEF_BLOCK_W;
endpackage

// File: rtl/cska_block.sv
// One ripple block of the carry-skip chain with its explicit skip multiplexer.
module cska_block
  import cska_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               cin,
  output logic [BLOCK_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);
  logic [BLOCK_W-1:0] p;
  logic [BLOCK_W-1:0] g;
  logic               blk_p;
  logic               rc;

  assign p     = a ^ b;
  assign g     = a & b;
  assign blk_p = &p;

  always_comb begin
    logic c;
    sum  = '0;
    cmsb = 1'b0;
    c    = cin;
    for (int i = 0; i < BLOCK_W; i++) begin
      sum[i] = p[i] ^ c;
      if (i == BLOCK_W - 1) cmsb = c;
      c = g[i] | (p[i] & c);
    end
    rc = c;
  end

  // When the whole block propagates, the incoming carry bypasses the ripple.
  assign cout = blk_p ? cin : rc;
endmodule

// File: rtl/cska_32bit.sv
// Registered 32-bit carry-skip adder {Cout,S} = A + B + Cin, one-cycle latency.
// Optional signed-overflow output Ovf is built when CSKA_OVF_EN is defined.
module cska_32bit
  import cska_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  output logic [DATA_W-1:0] S,
  output logic              Cout
`ifdef CSKA_OVF_EN
  ,
  output logic              Ovf
`endif
);
  // BLOCK_W must divide DATA_W evenly.
  localparam int NBLK = DATA_W / BLOCK_W;

  logic [DATA_W-1:0] s_d;
  logic [DATA_W-1:0] s_q;
  logic              cout_d;
  logic              cout_q;
  logic [NBLK-1:0]   blk_cmsb;
  logic              unused_cmsb;

  // Each generate scope owns its own carry nets so the chain is acyclic per net.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic cin_k;
    logic cout_k;
    if (k == 0) begin : g_first
      assign cin_k = Cin;
    end else begin : g_rest
      assign cin_k = g_blk[k-1].cout_k;
    end
    cska_block #(.BLOCK_W(BLOCK_W)) u_blk (
      .a    (A[k*BLOCK_W +: BLOCK_W]),
      .b    (B[k*BLOCK_W +: BLOCK_W]),
      .cin  (cin_k),
      .sum  (s_d[k*BLOCK_W +: BLOCK_W]),
      .cout (cout_k),
      .cmsb (blk_cmsb[k])
    );
  end

  assign cout_d      = g_blk[NBLK-1].cout_k;
  assign unused_cmsb = ^blk_cmsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;

`ifdef CSKA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into bit 31 differs from carry out of bit 31 exactly on signed overflow.
  assign ovf_d = blk_cmsb[NBLK-1] ^ cout_d;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cska_32bit.sv
// Directed and back-to-back random checks for cska_32bit (Ovf checked under CSKA_OVF_EN).
module tb_cska_32bit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;
  logic        ovf_obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef CSKA_OVF_EN
  logic Ovf;
  cska_32bit dut (.clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout), .Ovf(Ovf));
  assign ovf_obs = Ovf;
`else
  cska_32bit dut (.clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout));
  assign ovf_obs = 1'b0;
`endif

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let the rising edge register, sample 1 ns later.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    rst = r; A = a; B = b; Cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                     input logic [32:0] exp_sum, input logic exp_ovf);
    step(1'b0, a, b, c);
    chk(tag, {Cout, S}, exp_sum);
`ifdef CSKA_OVF_EN
    chk({tag, "_ovf"}, {32'd0, ovf_obs}, {32'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) chk({tag, "_ovf"}, {32'd0, ovf_obs}, 33'd0);
`endif
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] rs;
    logic        ro;

    rst = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; Cin = 1'b1;

    // Reset holds outputs at zero even with all-ones inputs.
    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("reset0", {Cout, S}, 33'd0);
    chk("reset0_ovf", {32'd0, ovf_obs}, 33'd0);
    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("reset1", {Cout, S}, 33'd0);

    vec("rel_ones",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 32'hFFFFFFFF}, 1'b0);
    step(1'b1, 32'h12345678, 32'h11111111, 1'b1);
    chk("midreset", {Cout, S}, 33'd0);
    chk("midreset_ovf", {32'd0, ovf_obs}, 33'd0);

    vec("skipchain",  32'hFFFF0000, 32'h0000FFFF, 1'b1, {1'b1, 32'h00000000}, 1'b0);
    vec("decimal",    32'd2017701177, 32'd1701853, 1'b0, {1'b0, 32'h785DA516}, 1'b0);
    vec("mixed",      32'hFFABCEDC, 32'hEF821EDA, 1'b1, {1'b1, 32'hEF2DEDB7}, 1'b0);
    vec("posovf",     32'h7FFFFFFF, 32'h00000000, 1'b1, {1'b0, 32'h80000000}, 1'b1);
    vec("negovf",     32'h80000000, 32'h80000000, 1'b0, {1'b1, 32'h00000000}, 1'b1);
    vec("cinprop",    32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000}, 1'b0);
    vec("zero",       32'h00000000, 32'h00000000, 1'b0, {1'b0, 32'h00000000}, 1'b0);
    vec("blkgen",     32'h0F0F0F0F, 32'h01010101, 1'b0, {1'b0, 32'h10101010}, 1'b0);

    // Back-to-back random vectors, one new sum each cycle.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      ro = (ra[31] == rb[31]) && (rs[31] != ra[31]);
      vec("rand", ra, rb, rc, rs, ro);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cska_32bit.md
# cska_32bit

Registered 32-bit carry-skip adder computing S = A + B + Cin with carry-out. It is the fast-add datapath element for 32-bit integer sums. A, B and Cin are added by a combinational carry-skip network of ripple blocks with skip multiplexers, and the result is captured in an output register. One sum is accepted every cycle.

## Interface
- BLOCK_W, default 4: width of each ripple/skip block. Must divide 32; 4 gives 8 blocks.
- clk  input  1  rising-edge clock; the one clock of the block.
- rst  input  1  synchronous, active-high reset.
- A  input  32  addend, unsigned or two's complement.
- B  input  32  addend.
- Cin  input  1  carry-in into bit 0.
- S  output  32  registered sum bits [31:0].
- Cout  output  1  registered carry out of bit 31.
- Ovf  output  1  registered signed overflow; present only with CSKA_OVF_EN.

## Operation
- Full sum is {Cout,S} = A + B + Cin as a 33-bit unsigned result. Wrap-around: S keeps the low 32 bits and Cout holds bit 32.
- Per bit: p_i = A_i ^ B_i, g_i = A_i & B_i, s_i = p_i ^ c_i, c_{i+1} = g_i | (p_i & c_i).
- Blocks: bits are split into 32/BLOCK_W blocks. Each block ripples internally from its block carry-in c_k.
- Block propagate: P_k = AND of p_i across the block.
- Block carry-out: c_{k+1} = P_k ? c_k : ripple carry-out. The skip mux must be explicit so the bypass path exists structurally.
- Block 0 carry-in is Cin. Cout is the carry-out of the last block.
- Ovf (when enabled) = carry into bit 31 XOR carry out of bit 31.
- There is no handshake or valid signal. Inputs are consumed on every clock edge.

## Timing
- Inputs are sampled on rising clk. S, Cout and Ovf update on that same edge.
- Latency is 1 cycle and throughput is 1 result per cycle.
- Reset: while rst=1 at an edge, S=32'h0, Cout=0, Ovf=0. Reset overrides any input.
- The first valid result appears on the first edge with rst=0.
- Reset asserted mid-stream: the pending sum is discarded and outputs read 0 after that edge.
- The combinational critical path is the all-propagate case (every P_k=1). Carry must pass through the skip muxes only and must not ripple through all 32 bits.
- Back-to-back input changes each produce exactly one output update, one cycle later. No stale or mixed results are allowed.

## Configuration
- CSKA_OVF_EN defined: the Ovf port and its register exist, computed as specified above, and are reset to 0.
- CSKA_OVF_EN undefined: no Ovf port, no extra logic. All other behaviour is unchanged.

## Structure
- A shared package cska_pkg holds:
  - DATA_W = 32
  - default BLOCK_W = 4
  - NUM_BLK = DATA_W/BLOCK_W
- Sub-module cska_block:
  - Inputs: BLOCK_W-bit a and b, plus cin.
  - Outputs: sum bits, block carry-out (skip mux included), and internal carry into the MSB (used for Ovf).
  - Instantiated NUM_BLK times with a generate loop and chained through carries.
- Top level contains the block chain plus the output register stage.

## Test plan
- A=32'hFFFF0000, B=32'h0000FFFF, Cin=1: full-propagate skip chain. Next cycle S=32'h00000000, Cout=1, Ovf=0.
- A=32'd2017701177, B=32'd1701853, Cin=0: next cycle S=32'h785DA516 (2019403030), Cout=0, Ovf=0.
- A=32'hFFABCEDC, B=32'hEF821EDA, Cin=1: next cycle S=32'hEF2DEDB7, Cout=1, Ovf=0.
- A=32'h7FFFFFFF, B=32'h00000000, Cin=1: S=32'h80000000, Cout=0, Ovf=1 (Ovf only when CSKA_OVF_EN defined).
- Reset: hold rst=1 with A=B=32'hFFFFFFFF, Cin=1 -> outputs stay 0. Release rst -> next cycle S=32'hFFFFFFFF, Cout=1. Reassert rst mid-stream -> outputs 0 on that edge.
- Randomized back-to-back vectors each cycle -> each {Cout,S} equals A+B+Cin from the previous cycle; includes the all-zero case (S=0, Cout=0).
